// File: rtl/priority_grant_dispatcher.sv
// rtl/priority_grant_dispatcher.sv - slot store feeding an 8-input lowest-value arbiter, issues ready/valid grants
// Optional anti-starvation aging: define PRIORITY_DISPATCH_AGING_EN.
module priority_grant_dispatcher #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           req_valid,
    input  logic [2:0]     req_slot,
    input  logic [N-1:0]   req_prio,
    output logic           req_ready,
    output logic [8*N-1:0] arb_in,
    input  logic [2:0]     arb_idx,
    output logic           gnt_valid,
    output logic [2:0]     gnt_idx,
    output logic [N-1:0]   gnt_prio,
    input  logic           gnt_ready,
    output logic [3:0]     occupancy
);

    localparam logic [N-1:0] PRIO_EMPTY    = '1;
    localparam logic [N-1:0] PRIO_MAX_REAL = {{(N-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        GRANT
    } state_t;

    state_t       state;
    logic [7:0]   slot_valid;
    logic [7:0]   slot_valid_nxt;
    logic [N-1:0] slot_prio     [8];
    logic [N-1:0] slot_prio_nxt [8];
    logic         wr_fire;
    logic         hs_fire;
    logic [N-1:0] wr_prio;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, v[i]};
        end
        return sum;
    endfunction

    // A slot still owned by the pending grant cannot be rewritten until its handshake clears it.
    always_comb begin
        req_ready = ~slot_valid[req_slot] & ~(gnt_valid & (gnt_idx == req_slot));
    end

    assign wr_fire = req_valid & req_ready;
    assign hs_fire = (state == GRANT) & gnt_ready;
    // All-ones is reserved for empty slots so any real request beats them.
    assign wr_prio = (req_prio == PRIO_EMPTY) ? PRIO_MAX_REAL : req_prio;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            arb_in[k*N +: N] = slot_valid[k] ? slot_prio[k] : PRIO_EMPTY;
        end
    end

    always_comb begin
        slot_valid_nxt = slot_valid;
        for (int k = 0; k < 8; k++) begin
            slot_prio_nxt[k] = slot_prio[k];
        end
        for (int k = 0; k < 8; k++) begin
            if (hs_fire && (gnt_idx == 3'(k))) begin
                slot_valid_nxt[k] = 1'b0;
                slot_prio_nxt[k]  = PRIO_EMPTY;
            end
`ifdef PRIORITY_DISPATCH_AGING_EN
            else if (hs_fire && slot_valid[k] && (slot_prio[k] != '0)) begin
                slot_prio_nxt[k] = slot_prio[k] - 1'b1;
            end
`endif
            if (wr_fire && (req_slot == 3'(k))) begin
                slot_valid_nxt[k] = 1'b1;
                slot_prio_nxt[k]  = wr_prio;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_valid <= '0;
            for (int k = 0; k < 8; k++) begin
                slot_prio[k] <= PRIO_EMPTY;
            end
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            gnt_prio  <= '0;
            occupancy <= '0;
        end else begin
            slot_valid <= slot_valid_nxt;
            for (int k = 0; k < 8; k++) begin
                slot_prio[k] <= slot_prio_nxt[k];
            end
            occupancy <= popcount8(slot_valid_nxt);

            case (state)
                IDLE: begin
                    if (|slot_valid) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // arb_in has had a full cycle to settle through the arbiter by now.
                    if (slot_valid[arb_idx]) begin
                        gnt_idx   <= arb_idx;
                        gnt_prio  <= slot_prio[arb_idx];
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        gnt_valid <= 1'b0;
                        state     <= SAMPLE;
                    end
                end
                default: begin
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
